// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Brief    : Shared constants and write-port priority helper for reg_file_mp.
// Revision : 1.0
// ============================================================================
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 2;

    // Hit vectors are zero-extended to this width so one helper serves any port count.
    localparam int C_MAX_WR = 16;
    localparam int C_SEL_W  = 4;

    typedef struct packed {
        logic               hit;
        logic [C_SEL_W-1:0] idx;
    } wr_sel_t;

    // Highest-indexed set bit wins; this is the write-conflict resolution rule.
    function automatic wr_sel_t hi_write_hit(input logic [C_MAX_WR-1:0] hits);
        wr_sel_t sel;
        sel = '0;
        for (int j = 0; j < C_MAX_WR; j++) begin
            if (hits[j]) begin
                sel.hit = 1'b1;
                sel.idx = C_SEL_W'(j);
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register busy bits with set-over-clear priority and busy count.
// Revision : 1.0
// ============================================================================
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     res_en,
    input  logic [ADDR_W-1:0]        res_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int C_DEPTH = 2**ADDR_W;
    localparam int C_CNT_W = ADDR_W + 1;

    logic [C_DEPTH-1:0] r_busy_q;
    logic [C_DEPTH-1:0] w_busy_d;
    logic [C_CNT_W-1:0] r_cnt_q;
    logic [C_CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_busy_d = r_busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                w_busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        // Reserve applied last: a newly issued producer outranks a retiring one.
        if (res_en) begin
            w_busy_d[res_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy_d[0] = 1'b0;
        end
        w_cnt_d = '0;
        for (int a = 0; a < C_DEPTH; a++) begin
            w_cnt_d = w_cnt_d + C_CNT_W'(w_busy_d[a]);
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] v_a;
        logic              v_hit;
        v_a     = '0;
        v_hit   = 1'b0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            v_a   = rd_addr[i*ADDR_W +: ADDR_W];
            v_hit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == v_a)) begin
                    v_hit = 1'b1;
                end
            end
            rd_busy[i] = r_busy_q[v_a] & ~v_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_q <= '0;
            r_cnt_q  <= '0;
        end else begin
            r_busy_q <= w_busy_d;
            r_cnt_q  <= w_cnt_d;
        end
    end

    assign busy_cnt = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : Multi-ported register file with write bypass, zero reg and scoreboard.
// Revision : 1.0
// ============================================================================
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     res_en,
    input  logic [ADDR_W-1:0]        res_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int C_DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem_q [C_DEPTH];
    logic [DATA_W-1:0] w_mem_d [C_DEPTH];

    always_comb begin
        logic [C_MAX_WR-1:0] v_hits;
        wr_sel_t             v_sel;
        v_hits = '0;
        v_sel  = '0;
        for (int a = 0; a < C_DEPTH; a++) begin
            v_hits = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                v_hits[j] = wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(a));
            end
            v_sel      = hi_write_hit(v_hits);
            w_mem_d[a] = r_mem_q[a];
            if (v_sel.hit && !((ZERO_REG != 0) && (a == 0))) begin
                w_mem_d[a] = wr_data[int'(v_sel.idx)*DATA_W +: DATA_W];
            end
        end
    end

    // Read path: same-cycle write data takes precedence over storage.
    always_comb begin
        logic [ADDR_W-1:0]   v_a;
        logic [C_MAX_WR-1:0] v_hits;
        wr_sel_t             v_sel;
        v_a     = '0;
        v_hits  = '0;
        v_sel   = '0;
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            v_a    = rd_addr[i*ADDR_W +: ADDR_W];
            v_hits = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                v_hits[j] = wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == v_a);
            end
            v_sel = hi_write_hit(v_hits);
            if ((ZERO_REG != 0) && (v_a == '0)) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if (v_sel.hit) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data[int'(v_sel.idx)*DATA_W +: DATA_W];
            end else begin
                rd_data[i*DATA_W +: DATA_W] = r_mem_q[v_a];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < C_DEPTH; a++) begin
                r_mem_q[a] <= '0;
            end
        end else begin
            for (int a = 0; a < C_DEPTH; a++) begin
                r_mem_q[a] <= w_mem_d[a];
            end
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .res_en   (res_en),
        .res_addr (res_addr),
        .busy_cnt (busy_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Brief    : Self-checking bench for reg_file_mp (default and narrow configs).
// Revision : 1.0
// ============================================================================
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        res_en;
    logic [4:0]  res_addr;
    logic [5:0]  busy_cnt;

    logic [8:0]  s_rd_addr;
    logic [47:0] s_rd_data;
    logic [2:0]  s_rd_busy;
    logic [0:0]  s_wr_en;
    logic [2:0]  s_wr_addr;
    logic [15:0] s_wr_data;
    logic        s_res_en;
    logic [2:0]  s_res_addr;
    logic [3:0]  s_busy_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    logic [15:0] s_mem  [8];

    always #5 clk = ~clk;

    reg_file_mp u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .res_en(res_en),
        .res_addr(res_addr), .busy_cnt(busy_cnt)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .NUM_WR(1)) u_dut_s (
        .clk(clk), .rst(rst), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .res_en(s_res_en),
        .res_addr(s_res_addr), .busy_cnt(s_busy_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: register array plus busy flags, updated by the architectural rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                m_mem[a]  <= '0;
                m_busy[a] <= 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0) begin
                    m_mem[wr_addr[j*5 +: 5]]  <= wr_data[j*32 +: 32];
                    m_busy[wr_addr[j*5 +: 5]] <= 1'b0;
                end
            end
            if (res_en && res_addr != 5'd0) m_busy[res_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input int p);
        logic [4:0]  a;
        logic [31:0] v;
        a = rd_addr[p*5 +: 5];
        if (a == 5'd0) return 32'd0;
        v = m_mem[a];
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*5 +: 5] == a) v = wr_data[j*32 +: 32];
        return v;
    endfunction

    function automatic logic exp_busy(input int p);
        logic [4:0] a;
        a = rd_addr[p*5 +: 5];
        if (a == 5'd0) return 1'b0;
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*5 +: 5] == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int a = 0; a < 32; a++) c += int'(m_busy[a]);
        return c;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("rd_data[%0d]", p), 64'(rd_data[p*32 +: 32]), 64'(exp_rd(p)));
                check($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(exp_busy(p)));
            end
            check("busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_main();
        wr_en  = '0;
        res_en = 1'b0;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; res_en = 1'b0; res_addr = '0;
        s_rd_addr = '0; s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0; s_res_en = 1'b0; s_res_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_data", rd_data, 64'd0);
        check("reset busy_cnt", 64'(busy_cnt), 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Write r5, then clear everything with an asynchronous reset.
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF}; rd_addr = {5'd0, 5'd5};
        #1 check("r5 bypass", 64'(rd_data[31:0]), 64'hDEADBEEF);
        step();
        idle_main();
        #1 check("r5 stored", 64'(rd_data[31:0]), 64'hDEADBEEF);
        rst = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            check("async reset rd_data", rd_data, 64'd0);
            check("async reset busy_cnt", 64'(busy_cnt), 64'd0);
        end
        rst = 1'b0;
        step();

        // Two ports write r7 in the same cycle; port 1 wins.
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr = {5'd1, 5'd7};
        #1 check("r7 bypass priority", 64'(rd_data[31:0]), 64'h22);
        step();
        idle_main();
        #1 check("r7 stored priority", 64'(rd_data[31:0]), 64'h22);

        // Scoreboard lifecycle on r3.
        res_en = 1'b1; res_addr = 5'd3; rd_addr = {5'd0, 5'd3};
        #1 check("r3 busy same cycle", 64'(rd_busy[0]), 64'd0);
        step();
        idle_main();
        #1 check("r3 busy next cycle", 64'(rd_busy[0]), 64'd1);
        check("r3 busy_cnt", 64'(busy_cnt), 64'd1);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h5};
        #1 check("r3 busy bypass", 64'(rd_busy[0]), 64'd0);
        check("r3 data bypass", 64'(rd_data[31:0]), 64'h5);
        step();
        idle_main();
        #1 check("r3 busy_cnt cleared", 64'(busy_cnt), 64'd0);

        // Reserve and write r9 together: data lands, busy stays set.
        res_en = 1'b1; res_addr = 5'd9; wr_en = 2'b01; wr_addr = {5'd0, 5'd9};
        wr_data = {32'd0, 32'h99}; rd_addr = {5'd0, 5'd9};
        step();
        idle_main();
        #1 check("r9 data", 64'(rd_data[31:0]), 64'h99);
        check("r9 busy", 64'(rd_busy[0]), 64'd1);
        check("r9 busy_cnt", 64'(busy_cnt), 64'd1);
        wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h9A, 32'd0};
        step();
        idle_main();
        #1 check("r9 busy_cnt cleared", 64'(busy_cnt), 64'd0);

        // Zero register ignores writes and reserves.
        wr_en = 2'b11; wr_addr = '0; wr_data = {64{1'b1}}; res_en = 1'b1; res_addr = 5'd0; rd_addr = '0;
        #1 check("r0 bypass data", rd_data, 64'd0);
        check("r0 bypass busy", 64'(rd_busy), 64'd0);
        step();
        idle_main();
        #1 check("r0 stored data", rd_data, 64'd0);
        check("r0 busy", 64'(rd_busy), 64'd0);
        check("r0 busy_cnt", 64'(busy_cnt), 64'd0);

        // Randomized traffic with one asynchronous reset pulse in the middle.
        for (int c = 0; c < 1500; c++) begin
            step();
            wr_en    = 2'($urandom_range(0, 3));
            wr_addr  = {rand_addr(), rand_addr()};
            wr_data  = {32'($urandom), 32'($urandom)};
            res_en   = ($urandom_range(0, 2) == 0);
            res_addr = rand_addr();
            rd_addr  = {rand_addr(), rand_addr()};
            if (c == 700) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        step();
        idle_main();

        // Narrow configuration: eight writes wrapping past address 7.
        for (int a = 0; a < 8; a++) s_mem[a] = '0;
        for (int k = 0; k < 8; k++) begin
            s_wr_en   = 1'b1;
            s_wr_addr = 3'((5 + k) & 7);
            s_wr_data = 16'(16'hA000 + k * 16'h0111);
            if (s_wr_addr != 3'd0) s_mem[s_wr_addr] = s_wr_data;
            step();
        end
        s_wr_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_rd_addr = {3'((k + 2) & 7), 3'((k + 1) & 7), 3'(k)};
            #1;
            for (int p = 0; p < 3; p++)
                check($sformatf("sweep rd_data[%0d] addr %0d", p, s_rd_addr[p*3 +: 3]),
                      64'(s_rd_data[p*16 +: 16]), 64'(s_mem[s_rd_addr[p*3 +: 3]]));
        end
        s_wr_en = 1'b1; s_wr_addr = 3'd7; s_wr_data = 16'h7E57; s_rd_addr = {3'd7, 3'd6, 3'd7};
        #1 check("sweep bypass r7", 64'(s_rd_data), {16'd0, 16'h7E57, s_mem[6], 16'h7E57});
        check("sweep busy_cnt", 64'(s_busy_cnt), 64'd0);
        step();
        s_wr_en = 1'b0;
        #1 check("sweep stored r7", 64'(s_rd_data[15:0]), 64'h7E57);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
